// File: rtl/shift_cmd_sequencer.sv
// shift_cmd_sequencer: turns accepted shift/rotate/load commands into per-cycle
// control and data for a downstream shift register. Optional queue: `SHIFT_CMD_SEQ_QUEUE_EN.
module shift_cmd_sequencer #(
    parameter int unsigned BITS = 8
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            cmdValid,
    output logic            cmdReady,
    input  logic [1:0]      cmdOp,
    input  logic [3:0]      cmdCount,
    input  logic [BITS-1:0] cmdData,
    input  logic [BITS-1:0] regFb,
    output logic [BITS-1:0] usrData,
    output logic [1:0]      usrCtrl,
    output logic            busy,
    output logic            cmdDone
);

    localparam int unsigned     IDXW      = (BITS > 1) ? $clog2(BITS) : 1;
    localparam logic [IDXW-1:0] IDX_LAST  = IDXW'(BITS - 1);
    localparam logic [1:0]      OP_SHL    = 2'b00;
    localparam logic [1:0]      OP_LOAD   = 2'b11;
    localparam logic [1:0]      CTRL_HOLD = 2'b11;

    typedef enum logic {
        S_IDLE,
        S_EXEC
    } state_t;

    state_t          r_state;
    state_t          w_next_state;
    logic [1:0]      r_op;
    logic [3:0]      r_rem;
    logic [IDXW-1:0] r_idx;
    logic [BITS-1:0] r_data;
    logic            r_done;

    logic            w_accept;
    logic            w_last;
    logic            w_load;
    logic [1:0]      w_new_op;
    logic [3:0]      w_new_cnt;
    logic [BITS-1:0] w_new_data;

    assign w_accept = cmdValid & cmdReady;
    assign w_last   = (r_state == S_EXEC) && (r_rem == 4'd0);

`ifdef SHIFT_CMD_SEQ_QUEUE_EN
    logic [1:0]      r_q_op   [0:1];
    logic [3:0]      r_q_cnt  [0:1];
    logic [BITS-1:0] r_q_data [0:1];
    logic            r_q_wr;
    logic            r_q_rd;
    logic [1:0]      r_q_fill;

    logic            w_slot_free;
    logic            w_q_empty;
    logic            w_push;
    logic            w_pop;

    assign w_q_empty   = (r_q_fill == 2'd0);
    assign cmdReady    = (r_q_fill != 2'd2);
    assign w_slot_free = (r_state == S_IDLE) || w_last;

    // Queued commands go first; an incoming command bypasses the queue only
    // when the queue is empty and the executor is free this cycle.
    assign w_pop      = w_slot_free && !w_q_empty;
    assign w_push     = w_accept && !(w_slot_free && w_q_empty);
    assign w_load     = w_slot_free && (w_accept || !w_q_empty);
    assign w_new_op   = w_q_empty ? cmdOp    : r_q_op[r_q_rd];
    assign w_new_cnt  = w_q_empty ? cmdCount : r_q_cnt[r_q_rd];
    assign w_new_data = w_q_empty ? cmdData  : r_q_data[r_q_rd];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_q_wr   <= 1'b0;
            r_q_rd   <= 1'b0;
            r_q_fill <= 2'd0;
            for (int unsigned i = 0; i < 2; i++) begin
                r_q_op[i]   <= '0;
                r_q_cnt[i]  <= '0;
                r_q_data[i] <= '0;
            end
        end else begin
            if (w_push) begin
                r_q_op[r_q_wr]   <= cmdOp;
                r_q_cnt[r_q_wr]  <= cmdCount;
                r_q_data[r_q_wr] <= cmdData;
                r_q_wr           <= ~r_q_wr;
            end
            if (w_pop) begin
                r_q_rd <= ~r_q_rd;
            end
            if (w_push && !w_pop) begin
                r_q_fill <= r_q_fill + 2'd1;
            end else if (w_pop && !w_push) begin
                r_q_fill <= r_q_fill - 2'd1;
            end
        end
    end
`else
    assign cmdReady   = (r_state == S_IDLE);
    assign w_load     = w_accept;
    assign w_new_op   = cmdOp;
    assign w_new_cnt  = cmdCount;
    assign w_new_data = cmdData;
`endif

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:  if (w_load) w_next_state = S_EXEC;
            S_EXEC:  if (w_last) w_next_state = w_load ? S_EXEC : S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
            r_op    <= '0;
            r_rem   <= '0;
            r_idx   <= '0;
            r_data  <= '0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_next_state;
            r_done  <= w_last;
            if (w_load) begin
                r_op   <= w_new_op;
                r_rem  <= (w_new_op == OP_LOAD) ? 4'd0 : w_new_cnt;
                r_idx  <= '0;
                r_data <= w_new_data;
            end else if (r_state == S_EXEC) begin
                if (r_rem != 4'd0) begin
                    r_rem <= r_rem - 4'd1;
                end
                r_idx <= (r_idx == IDX_LAST) ? '0 : r_idx + 1'b1;
            end
        end
    end

    // SHL feeds one serial bit per cycle into bit 0; upper bits stay clear.
    always_comb begin
        usrCtrl = CTRL_HOLD;
        usrData = regFb;
        if (r_state == S_EXEC) begin
            usrCtrl = r_op;
            if (r_op == OP_SHL) begin
                usrData    = '0;
                usrData[0] = r_data[r_idx];
            end else begin
                usrData = r_data;
            end
        end
    end

    assign busy    = (r_state == S_EXEC);
    assign cmdDone = r_done;

endmodule
